simon_key_reverse: RTL and testbench

- Sequential SIMON key scheduler for the decryption datapath; the inverse-direction counterpart of the forward key expansion.
- Accepts the M-word master key and runs the forward schedule internally to reach the last M round keys.
- Then walks the schedule backwards, streaming round keys k[T-1] down to k[0] over a valid/ready handshake to the decrypt round engine.

---
 rtl/simon_pkg.sv | 45 ++++
 rtl/simon_key_reverse_if.sv | 20 ++
 rtl/simon_key_step.sv | 30 +++
 rtl/simon_key_reverse.sv | 98 +++++++++
 tb/tb_simon_key_reverse.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared SIMON key-schedule definitions: z sequences, round function, constants, FSM states.
// Word-level helpers work on 64-bit containers and mask down to the active word size n.
package simon_pkg;

   typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

   // Bit i of sequence z_J is Z_SEQ[J][61-i] (leftmost character is index 0).
   localparam logic [61:0] Z_SEQ [5] = '{
      62'b11111010001001010110000111001101111101000100101011000011100110,
      62'b10001110111110010011000010110101000111011111001001100001011010,
      62'b10101111011100000011010010011000101000010001111110010110110011,
      62'b11011011101011000110010111100000010010001010011100110100001111,
      62'b11010001111001101011011000100000010111000011001010010011101111
   };

   function automatic logic [63:0] word_mask(input int n);
      return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] ror_n(input logic [63:0] x, input int r, input int n);
      logic [63:0] v;
      v = x & word_mask(n);
      return ((v >> r) | (v << (n - r))) & word_mask(n);
   endfunction

   function automatic logic [63:0] round_f(input logic [63:0] a, input logic [63:0] b,
                                           input int n, input int m);
      logic [63:0] t;
      t = ror_n(a, 3, n) ^ ((m == 4) ? (b & word_mask(n)) : 64'd0);
      return t ^ ror_n(t, 1, n);
   endfunction

   function automatic logic [63:0] c_const(input int n);
      return word_mask(n) & ~64'd3;
   endfunction

   function automatic logic z_bit(input int sel, input int idx);
      logic [61:0] z;
      logic [5:0]  b;
      z = Z_SEQ[3'(sel)];
      b = 6'(61 - (idx % 62));
      return z[b];
   endfunction

endpackage

// File: rtl/simon_key_reverse_if.sv
// Load/stream bundle between the key scheduler (slave) and its controller/consumer (master).
interface simon_key_reverse_if #(
   parameter int N = 16,
   parameter int M = 4,
   parameter int T = 32
);
   logic                   start;
   logic [M*N-1:0]         key_in;
   logic                   busy;
   logic                   key_valid;
   logic                   key_ready;
   logic [N-1:0]           key_out;
   logic [$clog2(T)-1:0]   key_idx;
   logic                   done;

   modport master (output start, key_in, key_ready,
                   input  busy, key_valid, key_out, key_idx, done);
   modport slave  (input  start, key_in, key_ready,
                   output busy, key_valid, key_out, key_idx, done);
endinterface

// File: rtl/simon_key_step.sv
// One SIMON key-schedule step over the M-word window, forward (next word) or reverse (previous word).
module simon_key_step import simon_pkg::*; #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic [M*N-1:0] i_win,
   input  logic           i_z,
   input  logic           i_rev,
   output logic [N-1:0]   o_word
);
   logic [63:0] w_a;
   logic [63:0] w_b;
   logic [63:0] w_base;
   logic [63:0] w_f;

   // Reverse inverts k[i] = c^z^k[i-M]^f(k[i-1],k[i-3]) by solving for k[i-M].
   always_comb begin
      if (i_rev) begin
         w_a    = 64'(i_win[(M-2)*N +: N]);
         w_b    = 64'(i_win[0 +: N]);
         w_base = 64'(i_win[(M-1)*N +: N]);
      end else begin
         w_a    = 64'(i_win[(M-1)*N +: N]);
         w_b    = 64'(i_win[N +: N]);
         w_base = 64'(i_win[0 +: N]);
      end
      w_f    = round_f(w_a, w_b, N, M);
      o_word = N'(c_const(N) ^ w_base ^ w_f ^ {63'd0, i_z});
   end
endmodule

// File: rtl/simon_key_reverse.sv
// SIMON inverse key scheduler: expands forward to the last M round keys, then streams
// k[T-1] .. k[0] over a valid/ready handshake by running the schedule backwards.
module simon_key_reverse import simon_pkg::*; #(
   parameter int N = 16,
   parameter int M = 4,
   parameter int T = 32,
   parameter int J = 0
) (
   input logic                clk,
   input logic                rst,
   simon_key_reverse_if.slave bus
);
   localparam int JW = $clog2(T + 1);
   localparam int IW = $clog2(T);

   state_t          r_state;
   state_t          w_state_nx;
   logic [M*N-1:0]  r_win;
   logic [JW-1:0]   r_j;
   logic [IW-1:0]   r_idx;
   logic            r_done;
   logic            w_hs;
   logic            w_last;
   logic            w_rev;
   logic            w_z;
   logic [N-1:0]    w_new;
   int              w_zidx;

   assign w_rev = (r_state == REV);

   always_comb begin
      w_zidx = int'(r_j);
      if (w_rev) w_zidx = (r_j == '0) ? 0 : int'(r_j) - 1;
      w_z = z_bit(J, w_zidx);
   end

   simon_key_step #(.N(N), .M(M)) u_step (
      .i_win  (r_win),
      .i_z    (w_z),
      .i_rev  (w_rev),
      .o_word (w_new)
   );

   always_comb begin
      w_state_nx = r_state;
      w_hs       = 1'b0;
      w_last     = 1'b0;
      unique case (r_state)
         IDLE: if (bus.start) w_state_nx = FWD;
         FWD:  if (r_j == JW'(T - M - 1)) w_state_nx = REV;
         REV: begin
            w_hs = bus.key_ready;
            if (w_hs && (r_idx == '0)) begin
               w_last     = 1'b1;
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Once j reaches 0 the window only drains; r_idx keeps counting the remaining keys.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_win   <= '0;
         r_j     <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_done  <= w_last;
         case (r_state)
            IDLE: if (bus.start) begin
               r_win <= bus.key_in;
               r_j   <= '0;
            end
            FWD: begin
               r_win <= {w_new, r_win[M*N-1:N]};
               r_j   <= r_j + JW'(1);
               if (r_j == JW'(T - M - 1)) r_idx <= IW'(T - 1);
            end
            REV: if (w_hs && !w_last) begin
               r_win <= {r_win[(M-1)*N-1:0], w_new};
               r_idx <= r_idx - IW'(1);
               if (r_j != '0) r_j <= r_j - JW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (r_state != IDLE);
   assign bus.key_valid = w_rev;
   assign bus.key_out   = r_win[(M-1)*N +: N];
   assign bus.key_idx   = r_idx;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_simon_key_reverse.sv
// Directed bench: SIMON32/64, 64/96 and 128/256 key streams checked against a forward model
// and by decrypting the published ciphertexts with the streamed keys.
module tb_simon_key_reverse;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   simon_key_reverse_if #(.N(16), .M(4), .T(32)) if0 ();
   simon_key_reverse_if #(.N(32), .M(3), .T(42)) if1 ();
   simon_key_reverse_if #(.N(64), .M(4), .T(72)) if2 ();

   simon_key_reverse #(.N(16), .M(4), .T(32), .J(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   simon_key_reverse #(.N(32), .M(3), .T(42), .J(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   simon_key_reverse #(.N(64), .M(4), .T(72), .J(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   int          sel;
   logic        start_d;
   logic        ready_d;
   logic [63:0] kw [4];
   logic [63:0] exp_k [72];
   int          errs = 0;
   int          checks = 0;

   assign if0.start     = start_d && (sel == 0);
   assign if1.start     = start_d && (sel == 1);
   assign if2.start     = start_d && (sel == 2);
   assign if0.key_ready = ready_d;
   assign if1.key_ready = ready_d;
   assign if2.key_ready = ready_d;
   assign if0.key_in    = {kw[3][15:0], kw[2][15:0], kw[1][15:0], kw[0][15:0]};
   assign if1.key_in    = {kw[2][31:0], kw[1][31:0], kw[0][31:0]};
   assign if2.key_in    = {kw[3], kw[2], kw[1], kw[0]};

   logic        obs_valid, obs_busy, obs_done;
   logic [63:0] obs_key;
   logic [31:0] obs_idx;

   always_comb begin
      obs_valid = 1'b0; obs_busy = 1'b0; obs_done = 1'b0; obs_key = '0; obs_idx = '0;
      case (sel)
         0: begin
            obs_valid = if0.key_valid; obs_busy = if0.busy; obs_done = if0.done;
            obs_key = 64'(if0.key_out); obs_idx = 32'(if0.key_idx);
         end
         1: begin
            obs_valid = if1.key_valid; obs_busy = if1.busy; obs_done = if1.done;
            obs_key = 64'(if1.key_out); obs_idx = 32'(if1.key_idx);
         end
         default: begin
            obs_valid = if2.key_valid; obs_busy = if2.busy; obs_done = if2.done;
            obs_key = 64'(if2.key_out); obs_idx = 32'(if2.key_idx);
         end
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] msk(input int n);
      return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
      logic [63:0] v;
      v = x & msk(n);
      return ((v >> r) | (v << (n - r))) & msk(n);
   endfunction

   function automatic logic [63:0] fsim(input logic [63:0] x, input int n);
      return (ror(x, n - 1, n) & ror(x, n - 8, n)) ^ ror(x, n - 2, n);
   endfunction

   function automatic logic [61:0] zsel(input int jz);
      case (jz)
         0: return 62'b11111010001001010110000111001101111101000100101011000011100110;
         1: return 62'b10001110111110010011000010110101000111011111001001100001011010;
         2: return 62'b10101111011100000011010010011000101000010001111110010110110011;
         3: return 62'b11011011101011000110010111100000010010001010011100110100001111;
         default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
      endcase
   endfunction

   // Textbook forward expansion: k[i] = ~k[i-m] ^ 3 ^ z[i-m] ^ tmp ^ ror1(tmp).
   task automatic expand(input int n, input int m, input int t, input int jz);
      logic [63:0] tmp;
      logic [61:0] zz;
      for (int i = 0; i < m; i++) exp_k[i] = kw[i] & msk(n);
      for (int i = m; i < t; i++) begin
         tmp = ror(exp_k[i-1], 3, n);
         if (m == 4) tmp = tmp ^ exp_k[i-3];
         tmp = tmp ^ ror(tmp, 1, n);
         zz  = zsel(jz) << ((i - m) % 62);
         exp_k[i] = (~exp_k[i-m] ^ tmp ^ {63'd0, zz[61]} ^ 64'd3) & msk(n);
      end
   endtask

   task automatic run_keys(input string tag, input int n, input int m, input int t, input int jz,
                           input bit rnd, input bit spam,
                           input logic [63:0] ch, input logic [63:0] cl,
                           input logic [63:0] ph, input logic [63:0] pl);
      int cyc, idx, dn;
      logic [63:0] dx, dy, tmp;
      expand(n, m, t, jz);
      dx = ch; dy = cl; dn = 0;
      ready_d = 1'b1; start_d = 1'b1; cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
         start_d = spam && (cyc % 3 == 0);
      end while (!obs_valid && cyc < 200);
      chk({tag, " latency"}, 64'(cyc), 64'(t - m + 1));
      idx = t - 1; cyc = 0;
      while (idx >= 0 && cyc < 1000) begin
         if (rnd) ready_d = ($urandom_range(0, 9) >= 3);
         chk({tag, " valid"}, 64'(obs_valid), 64'd1);
         chk({tag, " idx"}, 64'(obs_idx), 64'(idx));
         chk({tag, " key"}, obs_key, exp_k[idx]);
         if (ready_d) begin
            tmp = dx; dx = dy;
            dy  = (tmp ^ fsim(dx, n) ^ obs_key) & msk(n);
            idx--;
            if (idx < 0) start_d = 1'b0;
         end
         @(posedge clk); #1; cyc++;
         if (spam && idx >= 0) start_d = (cyc % 3 == 0);
         if (obs_done) dn++;
      end
      ready_d = 1'b1;
      chk({tag, " all keys"}, 64'(idx), 64'(-1));
      chk({tag, " done count"}, 64'(dn), 64'd1);
      chk({tag, " end valid"}, 64'(obs_valid), 64'd0);
      chk({tag, " end busy"}, 64'(obs_busy), 64'd0);
      chk({tag, " pt hi"}, dx, ph);
      chk({tag, " pt lo"}, dy, pl);
   endtask

   task automatic abort_run(input string tag, input int t, input int nkeys);
      int cyc, got;
      ready_d = 1'b1; start_d = 1'b1;
      @(posedge clk); #1; start_d = 1'b0; cyc = 1; got = 0;
      if (nkeys < 0) begin
         repeat (5) @(posedge clk);
         #1;
         chk({tag, " busy fwd"}, 64'(obs_busy), 64'd1);
         chk({tag, " valid fwd"}, 64'(obs_valid), 64'd0);
      end else begin
         while (got < nkeys && cyc < 200) begin
            if (obs_valid) got++;
            @(posedge clk); #1; cyc++;
         end
         chk({tag, " idx before rst"}, 64'(obs_idx), 64'(t - 1 - nkeys));
      end
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk({tag, " busy"}, 64'(obs_busy), 64'd0);
      chk({tag, " valid"}, 64'(obs_valid), 64'd0);
      chk({tag, " done"}, 64'(obs_done), 64'd0);
      chk({tag, " key_out"}, obs_key, 64'd0);
      chk({tag, " key_idx"}, 64'(obs_idx), 64'd0);
   endtask

   initial begin
      sel = 0; start_d = 1'b0; ready_d = 1'b1; rst = 1'b1;
      kw[0] = 64'h0100; kw[1] = 64'h0908; kw[2] = 64'h1110; kw[3] = 64'h1918;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 64'(obs_busy), 64'd0);
      chk("reset valid", 64'(obs_valid), 64'd0);
      chk("reset done", 64'(obs_done), 64'd0);
      chk("reset key_out", obs_key, 64'd0);
      chk("reset key_idx", 64'(obs_idx), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_keys("s32 basic", 16, 4, 32, 0, 1'b0, 1'b0, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      @(posedge clk); #1;
      chk("s32 basic done pulse", 64'(obs_done), 64'd0);

      run_keys("s32 stall", 16, 4, 32, 0, 1'b1, 1'b0, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      @(posedge clk); #1;
      chk("s32 stall done pulse", 64'(obs_done), 64'd0);

      run_keys("s32 spam", 16, 4, 32, 0, 1'b0, 1'b1, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      @(posedge clk); #1;
      chk("s32 spam idle", 64'(obs_busy), 64'd0);

      abort_run("rst fwd", 32, -1);
      run_keys("s32 after fwd rst", 16, 4, 32, 0, 1'b0, 1'b0, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      @(posedge clk); #1;

      abort_run("rst rev", 32, 10);
      run_keys("s32 after rev rst", 16, 4, 32, 0, 1'b0, 1'b0, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      run_keys("s32 b2b", 16, 4, 32, 0, 1'b1, 1'b0, 64'hc69b, 64'he9bb, 64'h6565, 64'h6877);
      @(posedge clk); #1;
      chk("s32 b2b done pulse", 64'(obs_done), 64'd0);

      sel = 1;
      kw[0] = 64'h03020100; kw[1] = 64'h0b0a0908; kw[2] = 64'h13121110; kw[3] = 64'h0;
      run_keys("s64/96", 32, 3, 42, 2, 1'b1, 1'b0,
               64'h5ca2e27f, 64'h111a8fc8, 64'h6f722067, 64'h6e696c63);
      @(posedge clk); #1;

      sel = 2;
      kw[0] = 64'h0706050403020100; kw[1] = 64'h0f0e0d0c0b0a0908;
      kw[2] = 64'h1716151413121110; kw[3] = 64'h1f1e1d1c1b1a1918;
      run_keys("s128/256", 64, 4, 72, 4, 1'b1, 1'b0,
               64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868, 64'h74206e69206d6f6f, 64'h6d69732061207369);
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
